// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage: registers one decoded instruction (control, indices, immediate, PC).
// Latency 1 cycle from accepted input to out_*; throughput 1/cycle with out_ready high.
// Backpressure: one-entry skid buffer absorbs a word when output is stalled; in_ready = !skid_valid.
// Optional M extension: define DECODE_M_EXTENSION_EN (adds out_m_op, widens out_alu_operation to 5 bits).
module decode_stage #(
    parameter int XLEN           = 32,
    parameter int REGISTER_COUNT = 32,
    parameter int PC_WIDTH       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instruction,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [XLEN-1:0]     out_immediate,
`ifdef DECODE_M_EXTENSION_EN
    output logic [4:0]          out_alu_operation,
    output logic [1:0]          out_m_op,
`else
    output logic [3:0]          out_alu_operation,
`endif
    output logic                out_alu_op1_pc,
    output logic                out_alu_op2_imm,
    output logic                out_rf_write_en,
    output logic [1:0]          out_rf_write_src,
    output logic                out_mem_read,
    output logic                out_mem_write,
    output logic [2:0]          out_mem_size,
    output logic [2:0]          out_branch_kind,
    output logic                out_branch,
    output logic                out_jump,
    output logic                out_jalr,
    output logic                out_system,
    output logic                out_illegal
);

`ifdef DECODE_M_EXTENSION_EN
    localparam int ALU_W = 5;
`else
    localparam int ALU_W = 4;
`endif

    localparam logic [ALU_W-1:0] ALU_ADD     = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB     = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_SLL     = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_SLT     = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_SLTU    = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_XOR     = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SRL     = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SRA     = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_OR      = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_AND     = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_INVALID = '1;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_IMM = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;
    localparam logic [1:0] WB_PC4 = 2'd3;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [XLEN-1:0]     imm;
        logic [ALU_W-1:0]    alu;
        logic                op1_pc;
        logic                op2_imm;
        logic                wen;
        logic [1:0]          wsrc;
        logic                mem_read;
        logic                mem_write;
        logic [2:0]          mem_size;
        logic [2:0]          branch_kind;
        logic                branch;
        logic                jump;
        logic                jalr;
        logic                system;
        logic                illegal;
`ifdef DECODE_M_EXTENSION_EN
        logic [1:0]          m_op;
`endif
    } dec_t;

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic        use_rd, use_rs1, use_rs2, bad;
    dec_t        dec, out_q, skid_q;
    logic        out_vld_q, skid_vld_q;

    assign opcode = in_instruction[6:0];
    assign f3     = in_instruction[14:12];
    assign f7     = in_instruction[31:25];
    assign imm_i  = {{20{in_instruction[31]}}, in_instruction[31:20]};
    assign imm_s  = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
    assign imm_b  = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                     in_instruction[30:25], in_instruction[11:8], 1'b0};
    assign imm_u  = {in_instruction[31:12], 12'b0};
    assign imm_j  = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                     in_instruction[20], in_instruction[30:21], 1'b0};

    // Combinational decode of the incoming word; illegal words collapse to a bare flag + INVALID op.
    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        bad     = 1'b0;
        imm32   = '0;
        case (opcode)
            7'b0110111: begin // LUI
                use_rd = 1'b1; imm32 = imm_u;
                dec.op2_imm = 1'b1; dec.wen = 1'b1; dec.wsrc = WB_IMM;
            end
            7'b0010111: begin // AUIPC
                use_rd = 1'b1; imm32 = imm_u;
                dec.op1_pc = 1'b1; dec.op2_imm = 1'b1; dec.wen = 1'b1;
            end
            7'b1101111: begin // JAL: ALU forms the target, rd gets PC+4
                use_rd = 1'b1; imm32 = imm_j;
                dec.op1_pc = 1'b1; dec.op2_imm = 1'b1; dec.jump = 1'b1;
                dec.wen = 1'b1; dec.wsrc = WB_PC4;
            end
            7'b1100111: begin // JALR
                use_rd = 1'b1; use_rs1 = 1'b1; imm32 = imm_i;
                dec.op2_imm = 1'b1; dec.jalr = 1'b1; dec.wen = 1'b1; dec.wsrc = WB_PC4;
                bad = (f3 != 3'b000);
            end
            7'b1100011: begin // BRANCH: ALU forms the target, compare happens in execute
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_b;
                dec.op1_pc = 1'b1; dec.op2_imm = 1'b1; dec.branch = 1'b1; dec.branch_kind = f3;
                bad = (f3 == 3'b010) || (f3 == 3'b011);
            end
            7'b0000011: begin // LOAD
                use_rd = 1'b1; use_rs1 = 1'b1; imm32 = imm_i;
                dec.op2_imm = 1'b1; dec.mem_read = 1'b1; dec.mem_size = f3;
                dec.wen = 1'b1; dec.wsrc = WB_MEM;
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            7'b0100011: begin // STORE
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_s;
                dec.op2_imm = 1'b1; dec.mem_write = 1'b1; dec.mem_size = f3;
                bad = (f3 >= 3'b011);
            end
            7'b0010011: begin // OP-IMM: ADDI never yields SUB; shifts check imm[11:5]
                use_rd = 1'b1; use_rs1 = 1'b1; imm32 = imm_i;
                dec.op2_imm = 1'b1; dec.wen = 1'b1;
                case (f3)
                    3'b000: dec.alu = ALU_ADD;
                    3'b001: begin dec.alu = ALU_SLL; bad = (f7 != 7'b0000000); end
                    3'b010: dec.alu = ALU_SLT;
                    3'b011: dec.alu = ALU_SLTU;
                    3'b100: dec.alu = ALU_XOR;
                    3'b101: begin
                        dec.alu = f7[5] ? ALU_SRA : ALU_SRL;
                        bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    end
                    3'b110: dec.alu = ALU_OR;
                    default: dec.alu = ALU_AND;
                endcase
            end
            7'b0110011: begin // OP
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dec.wen = 1'b1;
                if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    case (f3)
                        3'b000: dec.alu = f7[5] ? ALU_SUB : ALU_ADD;
                        3'b001: dec.alu = ALU_SLL;
                        3'b010: dec.alu = ALU_SLT;
                        3'b011: dec.alu = ALU_SLTU;
                        3'b100: dec.alu = ALU_XOR;
                        3'b101: dec.alu = f7[5] ? ALU_SRA : ALU_SRL;
                        3'b110: dec.alu = ALU_OR;
                        default: dec.alu = ALU_AND;
                    endcase
                end
`ifdef DECODE_M_EXTENSION_EN
                // MUL..DIVU map to 10..15; REM/REMU reuse DIV/DIVU codes with m_op[1] = remainder.
                else if (f7 == 7'b0000001) begin
                    dec.alu  = (f3[2] && f3[1]) ? ALU_W'(14 + f3[0]) : ALU_W'(10 + f3);
                    dec.m_op = {f3[2] & f3[1], 1'b1};
                end
`endif
                else begin
                    bad = 1'b1;
                end
            end
            7'b0001111: bad = (f3 != 3'b000); // FENCE: legal no-op
            7'b1110011: dec.system = 1'b1;     // ECALL/EBREAK/CSR: flagged only
            default:    bad = 1'b1;
        endcase

        if (use_rd  && int'(in_instruction[11:7])  >= REGISTER_COUNT) bad = 1'b1;
        if (use_rs1 && int'(in_instruction[19:15]) >= REGISTER_COUNT) bad = 1'b1;
        if (use_rs2 && int'(in_instruction[24:20]) >= REGISTER_COUNT) bad = 1'b1;

        dec.rd  = use_rd  ? in_instruction[11:7]  : 5'd0;
        dec.rs1 = use_rs1 ? in_instruction[19:15] : 5'd0;
        dec.rs2 = use_rs2 ? in_instruction[24:20] : 5'd0;
        dec.imm = XLEN'($signed(imm32));
        dec.wen = dec.wen && (dec.rd != 5'd0);

        if (bad) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
            dec.alu     = ALU_INVALID;
        end
    end

    // Output register plus skid: output loads when empty/draining, otherwise the word parks in skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (!out_vld_q || out_ready) begin
            if (skid_vld_q) begin
                out_q      <= skid_q;
                out_vld_q  <= 1'b1;
                skid_vld_q <= 1'b0;
            end else begin
                out_vld_q <= in_valid;
                if (in_valid) out_q <= dec;
            end
        end else if (in_valid && !skid_vld_q) begin
            skid_q     <= dec;
            skid_vld_q <= 1'b1;
        end
    end

    assign in_ready          = ~skid_vld_q;
    assign out_valid         = out_vld_q;
    assign out_pc            = out_q.pc;
    assign out_rd            = out_q.rd;
    assign out_rs1           = out_q.rs1;
    assign out_rs2           = out_q.rs2;
    assign out_immediate     = out_q.imm;
    assign out_alu_operation = out_q.alu;
    assign out_alu_op1_pc    = out_q.op1_pc;
    assign out_alu_op2_imm   = out_q.op2_imm;
    assign out_rf_write_en   = out_q.wen;
    assign out_rf_write_src  = out_q.wsrc;
    assign out_mem_read      = out_q.mem_read;
    assign out_mem_write     = out_q.mem_write;
    assign out_mem_size      = out_q.mem_size;
    assign out_branch_kind   = out_q.branch_kind;
    assign out_branch        = out_q.branch;
    assign out_jump          = out_q.jump;
    assign out_jalr          = out_q.jalr;
    assign out_system        = out_q.system;
    assign out_illegal       = out_q.illegal;
`ifdef DECODE_M_EXTENSION_EN
    assign out_m_op          = out_q.m_op;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed stimulus, queue scoreboard of expected decoded words.
// Second instance with REGISTER_COUNT=16 checks the RV32E register-range rule.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instruction, in_pc;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        op1_pc, op2_imm, wen;
        logic [1:0]  wsrc;
        logic        mrd, mwr;
        logic [2:0]  msize;
        logic        br;
        logic [2:0]  kind;
        logic        j, jr, sys, ill;
    } exp_t;

    // main instance (RV32I)
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_immediate;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [3:0]  out_alu_operation;
    logic        out_alu_op1_pc, out_alu_op2_imm, out_rf_write_en;
    logic [1:0]  out_rf_write_src;
    logic        out_mem_read, out_mem_write, out_branch, out_jump, out_jalr, out_system, out_illegal;
    logic [2:0]  out_mem_size, out_branch_kind;

    // RV32E instance
    logic        e_in_ready, e_out_valid;
    logic [31:0] e_out_pc, e_out_immediate;
    logic [4:0]  e_out_rd, e_out_rs1, e_out_rs2;
    logic [3:0]  e_out_alu_operation;
    logic        e_out_alu_op1_pc, e_out_alu_op2_imm, e_out_rf_write_en;
    logic [1:0]  e_out_rf_write_src;
    logic        e_out_mem_read, e_out_mem_write, e_out_branch, e_out_jump, e_out_jalr, e_out_system, e_out_illegal;
    logic [2:0]  e_out_mem_size, e_out_branch_kind;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_immediate(out_immediate), .out_alu_operation(out_alu_operation),
        .out_alu_op1_pc(out_alu_op1_pc), .out_alu_op2_imm(out_alu_op2_imm),
        .out_rf_write_en(out_rf_write_en), .out_rf_write_src(out_rf_write_src),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_mem_size(out_mem_size),
        .out_branch_kind(out_branch_kind), .out_branch(out_branch), .out_jump(out_jump),
        .out_jalr(out_jalr), .out_system(out_system), .out_illegal(out_illegal)
    );

    decode_stage #(.REGISTER_COUNT(16)) dut_e (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .out_valid(e_out_valid), .out_ready(out_ready),
        .out_pc(e_out_pc), .out_rd(e_out_rd), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2),
        .out_immediate(e_out_immediate), .out_alu_operation(e_out_alu_operation),
        .out_alu_op1_pc(e_out_alu_op1_pc), .out_alu_op2_imm(e_out_alu_op2_imm),
        .out_rf_write_en(e_out_rf_write_en), .out_rf_write_src(e_out_rf_write_src),
        .out_mem_read(e_out_mem_read), .out_mem_write(e_out_mem_write), .out_mem_size(e_out_mem_size),
        .out_branch_kind(e_out_branch_kind), .out_branch(e_out_branch), .out_jump(e_out_jump),
        .out_jalr(e_out_jalr), .out_system(e_out_system), .out_illegal(e_out_illegal)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t pend;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t obs_main();
        return {out_pc, out_rd, out_rs1, out_rs2, out_immediate, out_alu_operation, out_alu_op1_pc,
                out_alu_op2_imm, out_rf_write_en, out_rf_write_src, out_mem_read, out_mem_write,
                out_mem_size, out_branch, out_branch_kind, out_jump, out_jalr, out_system, out_illegal};
    endfunction

    function automatic exp_t obs_e();
        return {e_out_pc, e_out_rd, e_out_rs1, e_out_rs2, e_out_immediate, e_out_alu_operation, e_out_alu_op1_pc,
                e_out_alu_op2_imm, e_out_rf_write_en, e_out_rf_write_src, e_out_mem_read, e_out_mem_write,
                e_out_mem_size, e_out_branch, e_out_branch_kind, e_out_jump, e_out_jalr, e_out_system, e_out_illegal};
    endfunction

    function automatic exp_t ex(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [3:0] alu);
        exp_t e = '0;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.alu = alu;
        return e;
    endfunction

    function automatic exp_t ill();
        exp_t e = '0;
        e.alu = 4'd15; e.ill = 1'b1;
        return e;
    endfunction

    // Scoreboard: pop/compare on output transfer, push on input transfer, flush empties it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) check("spurious_output", 128'(q.size()), 128'(1));
                    else check("out_word", 128'(obs_main()), 128'(q.pop_front()));
                end
                if (in_valid && in_ready) q.push_back(pend);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
        in_valid = 1'b1; in_instruction = ins; in_pc = pc;
        e.pc = pc; pend = e;
    endtask

    task automatic wait_accept();
        bit acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        check("accept", 128'(acc), 128'(1));
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
        drive(ins, pc, e);
        wait_accept();
    endtask

    task automatic wait_empty(input string tag);
        for (int k = 0; k < 30 && (q.size() != 0 || out_valid); k++) step();
        check(tag, 128'(q.size()), 128'(0));
    endtask

    logic [31:0] t_ins [18];
    exp_t        t_exp [18];
    exp_t        e;
    int          c0;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instruction = '0; in_pc = '0; pend = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset / idle state
        @(negedge clk);
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(1));
        check("reset_outputs", 128'(obs_main()), 128'(0));
        check("reset_e_in_ready", 128'(e_in_ready), 128'(1));

        // addi x1,x0,5 with latency 1
        step();
        out_ready = 1'b1;
        e = ex(5'd1, 5'd0, 5'd0, 32'd5, 4'd0); e.op2_imm = 1'b1; e.wen = 1'b1;
        send(32'h0050_0093, 32'h100, e);
        in_valid = 1'b0;
        @(negedge clk);
        check("addi_latency", 128'(out_valid), 128'(1));
        wait_empty("addi_drain");

        // back-to-back 3 words with output stalled
        out_ready = 1'b0;
        e = ex(5'd2, 5'd1, 5'd2, 32'd0, 4'd0); e.wen = 1'b1;
        drive(32'h0020_8133, 32'h110, e);
        step();
        e = ex(5'd3, 5'd1, 5'd2, 32'd0, 4'd1); e.wen = 1'b1;
        drive(32'h4020_81B3, 32'h114, e);
        step();
        e = ex(5'd5, 5'd1, 5'd0, 32'd8, 4'd0); e.op2_imm = 1'b1; e.wen = 1'b1;
        e.wsrc = 2'd2; e.mrd = 1'b1; e.msize = 3'd2;
        drive(32'h0080_A283, 32'h118, e);
        @(negedge clk);
        check("b2b_in_ready_low", 128'(in_ready), 128'(0));
        check("b2b_out_valid", 128'(out_valid), 128'(1));
        check("b2b_queued", 128'(q.size()), 128'(2));
        out_ready = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        wait_empty("b2b_drain");

        // decode table, streamed back-to-back
        t_ins[0]  = 32'hFE00_0EE3; t_exp[0]  = ex(0, 0, 0, 32'hFFFF_FFFC, 0);
        t_exp[0].op1_pc = 1; t_exp[0].op2_imm = 1; t_exp[0].br = 1; t_exp[0].kind = 3'd0;
        t_ins[1]  = 32'h4030_D093; t_exp[1]  = ex(1, 1, 0, 32'h0000_0403, 7);
        t_exp[1].op2_imm = 1; t_exp[1].wen = 1;
        t_ins[2]  = 32'h1234_53B7; t_exp[2]  = ex(7, 0, 0, 32'h1234_5000, 0);
        t_exp[2].op2_imm = 1; t_exp[2].wen = 1; t_exp[2].wsrc = 2'd1;
        t_ins[3]  = 32'h0080_00EF; t_exp[3]  = ex(1, 0, 0, 32'd8, 0);
        t_exp[3].op1_pc = 1; t_exp[3].op2_imm = 1; t_exp[3].wen = 1; t_exp[3].wsrc = 2'd3; t_exp[3].j = 1;
        t_ins[4]  = 32'h0FF0_000F; t_exp[4]  = ex(0, 0, 0, 32'd0, 0);
        t_ins[5]  = 32'h0000_0013; t_exp[5]  = ex(0, 0, 0, 32'd0, 0); t_exp[5].op2_imm = 1;
        t_ins[6]  = 32'h0231_00B3; t_exp[6]  = ill();
        t_ins[7]  = 32'hFFFF_FFFF; t_exp[7]  = ill();
        t_ins[8]  = 32'h0010_B023; t_exp[8]  = ill();
        t_ins[9]  = 32'h4030_9093; t_exp[9]  = ill();
        t_ins[10] = 32'h0020_A223; t_exp[10] = ex(0, 1, 2, 32'd4, 0);
        t_exp[10].op2_imm = 1; t_exp[10].mwr = 1; t_exp[10].msize = 3'd2;
        t_ins[11] = 32'h0000_8067; t_exp[11] = ex(0, 1, 0, 32'd0, 0);
        t_exp[11].op2_imm = 1; t_exp[11].wsrc = 2'd3; t_exp[11].jr = 1;
        t_ins[12] = 32'h0020_C463; t_exp[12] = ex(0, 1, 2, 32'd8, 0);
        t_exp[12].op1_pc = 1; t_exp[12].op2_imm = 1; t_exp[12].br = 1; t_exp[12].kind = 3'd4;
        t_ins[13] = 32'h0020_A233; t_exp[13] = ex(4, 1, 2, 32'd0, 3); t_exp[13].wen = 1;
        t_ins[14] = 32'hFFF0_B293; t_exp[14] = ex(5, 1, 0, 32'hFFFF_FFFF, 4);
        t_exp[14].op2_imm = 1; t_exp[14].wen = 1;
        t_ins[15] = 32'h0000_0073; t_exp[15] = ex(0, 0, 0, 32'd0, 0); t_exp[15].sys = 1;
        t_ins[16] = 32'h0000_2063; t_exp[16] = ill();
        t_ins[17] = 32'h0000_1197; t_exp[17] = ex(3, 0, 0, 32'h0000_1000, 0);
        t_exp[17].op1_pc = 1; t_exp[17].op2_imm = 1; t_exp[17].wen = 1;
        c0 = cyc;
        for (int i = 0; i < 18; i++) send(t_ins[i], 32'h200 + 32'(i * 4), t_exp[i]);
        check("throughput_cycles", 128'(cyc - c0), 128'(18));
        in_valid = 1'b0;
        wait_empty("table_drain");

        // RV32E: x16 is out of range on the 16-register instance
        e = ex(5'd16, 5'd0, 5'd0, 32'd16, 4'd0); e.op2_imm = 1'b1; e.wen = 1'b1;
        send(32'h0100_0813, 32'h300, e);
        in_valid = 1'b0;
        @(negedge clk);
        check("rv32e_valid", 128'(e_out_valid), 128'(1));
        e = ill(); e.pc = 32'h300;
        check("rv32e_x16_illegal", 128'(obs_e()), 128'(e));
        wait_empty("rv32e_drain");

        // flush with output and skid full and a word offered
        out_ready = 1'b0;
        e = ex(5'd1, 5'd0, 5'd0, 32'd5, 4'd0); e.op2_imm = 1'b1; e.wen = 1'b1;
        send(32'h0050_0093, 32'h400, e);
        send(32'h0050_0093, 32'h404, e);
        drive(32'h0050_0093, 32'h408, e);
        flush = 1'b1;
        @(negedge clk);
        check("flush_pre_full", 128'(in_ready), 128'(0));
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_in_ready", 128'(in_ready), 128'(1));
        check("flush_e_out_valid", 128'(e_out_valid), 128'(0));

        // flush drops a same-cycle input transfer
        step();
        out_ready = 1'b1;
        drive(32'h0050_0093, 32'h500, e);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_drop_in", 128'(out_valid), 128'(0));

        // stage resumes after flush
        step();
        e = ex(5'd7, 5'd0, 5'd0, 32'h1234_5000, 4'd0); e.op2_imm = 1'b1; e.wen = 1'b1; e.wsrc = 2'd1;
        send(32'h1234_53B7, 32'h600, e);
        in_valid = 1'b0;
        wait_empty("resume_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
